lsu_pipelined: RTL and testbench

//  Parametrised load/store execution unit between the LSU reservation station and the data cache/memory.

---
 rtl/lsu_pipelined_if.sv | 58 +++++
 rtl/lsu_pipelined.sv | 270 +++++++++++++++++++++++++++
 tb/tb_lsu_pipelined.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pipelined_if.sv
// Issue, completion and memory buses of the load/store unit.
// slave = unit side, master = reservation station / writeback / memory side.
interface lsu_pipelined_if #(
   parameter int RS_ID_WIDTH = 5
);
   logic                   input_valid;
   logic                   input_ready;
   logic [RS_ID_WIDTH-1:0] rs_id_in;
   logic [4:0]             result_reg_addr_in;
   logic [31:0]            op1;
   logic [31:0]            op2;
   logic [31:0]            source;
   logic                   store;
   logic [1:0]             size;
   logic                   sign_ext;
   logic                   byte_rev;

   logic                   output_valid;
   logic                   output_ready;
   logic [RS_ID_WIDTH-1:0] rs_id_out;
   logic [4:0]             result_reg_addr_out;
   logic [31:0]            result;
   logic                   align_error;

   logic                   to_mem_valid;
   logic                   to_mem_ready;
   logic [31:0]            mem_address;
   logic [3:0]             mem_write_en;
   logic [3:0]             mem_read_en;
   logic [31:0]            mem_write_data;
   logic                   from_mem_valid;
   logic                   from_mem_ready;
   logic [31:0]            mem_read_data;

   modport slave (
      input  input_valid, rs_id_in, result_reg_addr_in, op1, op2, source,
             store, size, sign_ext, byte_rev,
      output input_ready,
      output output_valid, rs_id_out, result_reg_addr_out, result, align_error,
      input  output_ready,
      output to_mem_valid, mem_address, mem_write_en, mem_read_en, mem_write_data,
      input  to_mem_ready,
      input  from_mem_valid, mem_read_data,
      output from_mem_ready
   );

   modport master (
      output input_valid, rs_id_in, result_reg_addr_in, op1, op2, source,
             store, size, sign_ext, byte_rev,
      input  input_ready,
      input  output_valid, rs_id_out, result_reg_addr_out, result, align_error,
      output output_ready,
      input  to_mem_valid, mem_address, mem_write_en, mem_read_en, mem_write_data,
      output to_mem_ready,
      output from_mem_valid, mem_read_data,
      input  from_mem_ready
   );
endinterface

// File: rtl/lsu_pipelined.sv
// Pipelined load/store unit: EA add, big-endian lane steering, in-order in-flight FIFO, load align/extend.
// Latency: issue -> request 1 cycle after capture; response -> completion next cycle. Optional LSU_BYTE_REVERSE_EN.
// Backpressure: input_ready drops when S0/S1 are full; requests capped at MAX_OUTSTANDING; output stall holds responses.
module lsu_pipelined #(
   parameter int RS_ID_WIDTH     = 5,
   parameter int MAX_OUTSTANDING = 4
) (
   input logic             clk,
   input logic             rst,
   lsu_pipelined_if.slave  bus
);
   // Spec bit 0 (MSB) is bit 31 here; byte lane i sits at enable bit 3-i.
`ifdef LSU_BYTE_REVERSE_EN
   localparam bit REV_EN = 1'b1;
`else
   localparam bit REV_EN = 1'b0;
`endif

   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

   typedef struct packed {
      logic [RS_ID_WIDTH-1:0] rs_id;
      logic [4:0]             rd;
      logic [31:0]            op1;
      logic [31:0]            op2;
      logic [31:0]            src;
      logic                   store;
      logic [1:0]             size;
      logic                   sext;
      logic                   brev;
   } s0_t;

   typedef struct packed {
      logic [RS_ID_WIDTH-1:0] rs_id;
      logic [4:0]             rd;
      logic [31:0]            addr;
      logic [3:0]             lanes;
      logic [31:0]            wdata;
      logic                   store;
      logic [1:0]             size;
      logic [1:0]             off;
      logic                   sext;
      logic                   brev;
      logic                   err;
   } req_t;

   typedef struct packed {
      logic [RS_ID_WIDTH-1:0] rs_id;
      logic [4:0]             rd;
      logic                   store;
      logic [1:0]             size;
      logic [1:0]             off;
      logic                   sext;
      logic                   brev;
      logic                   err;
   } ent_t;

   typedef struct packed {
      logic [RS_ID_WIDTH-1:0] rs_id;
      logic [4:0]             rd;
      logic [31:0]            result;
      logic                   err;
   } out_t;

   function automatic logic [31:0] swap_bytes(input logic [31:0] d, input logic [1:0] sz);
      logic [31:0] r;
      r = d;
      if (sz == 2'd1)
         r = {16'h0, d[7:0], d[15:8]};
      else if (sz == 2'd3)
         r = {d[7:0], d[15:8], d[23:16], d[31:24]};
      return r;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   logic             s0_vld_q, s0_vld_d;
   s0_t              s0_q, s0_d;
   logic             s1_vld_q, s1_vld_d;
   req_t             s1_q, s1_d;
   ent_t             fifo_q [MAX_OUTSTANDING];
   ent_t             fifo_d [MAX_OUTSTANDING];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_vld_q, out_vld_d;
   out_t             out_q, out_d;

   req_t             req_new;
   logic [31:0]      ea;
   logic [31:0]      sdat;
   ent_t             head;
   logic [31:0]      raw;
   logic [31:0]      ld_val;
   logic             head_vld, out_free, slot_free;
   logic             pop_norm, pop_err, pop, push;
   logic             req_vld, s1_fire, s1_load, s0_adv, in_rdy;

   // Effective address and lane steering for the op sitting in S0.
   always_comb begin
      ea              = s0_q.op1 + s0_q.op2;
      req_new         = '0;
      req_new.rs_id   = s0_q.rs_id;
      req_new.rd      = s0_q.rd;
      req_new.addr    = {ea[31:2], 2'b00};
      req_new.store   = s0_q.store;
      req_new.size    = s0_q.size;
      req_new.off     = ea[1:0];
      req_new.sext    = s0_q.sext;
      req_new.brev    = s0_q.brev;
      sdat            = (REV_EN && s0_q.brev) ? swap_bytes(s0_q.src, s0_q.size) : s0_q.src;
      case (s0_q.size)
         2'd0: begin
            req_new.lanes = 4'b1000 >> ea[1:0];
            req_new.wdata = {sdat[7:0], 24'h0} >> {ea[1:0], 3'b000};
         end
         2'd1: begin
            req_new.err   = (ea[1:0] == 2'd3);
            req_new.lanes = 4'b1100 >> ea[1:0];
            req_new.wdata = {sdat[15:0], 16'h0} >> {ea[1:0], 3'b000};
         end
         2'd3: begin
            req_new.err   = (ea[1:0] != 2'd0);
            req_new.lanes = 4'b1111;
            req_new.wdata = sdat;
         end
         default: req_new.err = 1'b1;
      endcase
      if (req_new.err) begin
         req_new.lanes = '0;
         req_new.wdata = '0;
      end
   end

   // Load data: pick the enabled lanes, right-justify, optionally reverse, then extend.
   always_comb begin
      head = fifo_q[rd_ptr_q];
      case (head.size)
         2'd0:    raw = (bus.mem_read_data >> {~head.off, 3'b000}) & 32'h0000_00FF;
         2'd1:    raw = (bus.mem_read_data >> {2'd2 - head.off, 3'b000}) & 32'h0000_FFFF;
         default: raw = bus.mem_read_data;
      endcase
      if (REV_EN && head.brev)
         raw = swap_bytes(raw, head.size);
      ld_val = raw;
      if (head.sext && head.size == 2'd0)
         ld_val = {{24{raw[7]}}, raw[7:0]};
      else if (head.sext && head.size == 2'd1)
         ld_val = {{16{raw[15]}}, raw[15:0]};
   end

   always_comb begin
      head_vld  = (cnt_q != '0);
      out_free  = !out_vld_q || bus.output_ready;
      pop_norm  = head_vld && !head.err && bus.from_mem_valid && out_free;
      pop_err   = head_vld && head.err && out_free;
      pop       = pop_norm || pop_err;
      // Error ops never hit memory, so a slot freed this cycle is usable at once.
      slot_free = (cnt_q < MAX_CNT) || pop;
      req_vld   = s1_vld_q && !s1_q.err && (cnt_q < MAX_CNT);
      s1_fire   = s1_vld_q && (s1_q.err ? slot_free : (req_vld && bus.to_mem_ready));
      push      = s1_fire;
      s1_load   = !s1_vld_q || s1_fire;
      s0_adv    = s0_vld_q && s1_load;
      in_rdy    = !s0_vld_q || s1_load;
   end

   always_comb begin
      s0_vld_d = s0_vld_q;
      s0_d     = s0_q;
      if (s0_adv)
         s0_vld_d = 1'b0;
      if (bus.input_valid && in_rdy) begin
         s0_vld_d   = 1'b1;
         s0_d.rs_id = bus.rs_id_in;
         s0_d.rd    = bus.result_reg_addr_in;
         s0_d.op1   = bus.op1;
         s0_d.op2   = bus.op2;
         s0_d.src   = bus.source;
         s0_d.store = bus.store;
         s0_d.size  = bus.size;
         s0_d.sext  = bus.sign_ext;
         s0_d.brev  = bus.byte_rev;
      end

      s1_vld_d = s1_vld_q;
      s1_d     = s1_q;
      if (s1_fire)
         s1_vld_d = 1'b0;
      if (s0_adv) begin
         s1_vld_d = 1'b1;
         s1_d     = req_new;
      end
   end

   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         fifo_d[wr_ptr_q] = '{rs_id: s1_q.rs_id, rd: s1_q.rd, store: s1_q.store,
                              size: s1_q.size, off: s1_q.off, sext: s1_q.sext,
                              brev: s1_q.brev, err: s1_q.err};
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop)
         rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_comb begin
      out_vld_d = out_vld_q && !bus.output_ready;
      out_d     = out_q;
      if (pop) begin
         out_vld_d    = 1'b1;
         out_d.rs_id  = head.rs_id;
         out_d.rd     = head.rd;
         out_d.err    = head.err;
         out_d.result = (head.err || head.store) ? 32'h0 : ld_val;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_vld_q  <= 1'b0;
         s0_q      <= '0;
         s1_vld_q  <= 1'b0;
         s1_q      <= '0;
         fifo_q    <= '{default: '0};
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         out_vld_q <= 1'b0;
         out_q     <= '0;
      end else begin
         s0_vld_q  <= s0_vld_d;
         s0_q      <= s0_d;
         s1_vld_q  <= s1_vld_d;
         s1_q      <= s1_d;
         fifo_q    <= fifo_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         out_vld_q <= out_vld_d;
         out_q     <= out_d;
      end
   end

   assign bus.input_ready         = in_rdy;
   assign bus.to_mem_valid        = req_vld;
   assign bus.mem_address         = s1_q.addr;
   assign bus.mem_write_en        = s1_q.store ? s1_q.lanes : 4'b0000;
   assign bus.mem_read_en         = s1_q.store ? 4'b0000 : s1_q.lanes;
   assign bus.mem_write_data      = s1_q.wdata;
   assign bus.from_mem_ready      = head_vld && !head.err && out_free;
   assign bus.output_valid        = out_vld_q;
   assign bus.rs_id_out           = out_q.rs_id;
   assign bus.result_reg_addr_out = out_q.rd;
   assign bus.result              = out_q.result;
   assign bus.align_error         = out_q.err;
endmodule

// File: tb/tb_lsu_pipelined.sv
// Directed bench for lsu_pipelined (MAX_OUTSTANDING = 2); expected values hand-computed.
module tb_lsu_pipelined;
   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;

   lsu_pipelined_if #(.RS_ID_WIDTH(5)) bus ();

   lsu_pipelined #(.RS_ID_WIDTH(5), .MAX_OUTSTANDING(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive_op(input logic [4:0] rs, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] src, input logic st, input logic [1:0] sz,
                           input logic sx, input logic rv);
      bus.rs_id_in           = rs;
      bus.result_reg_addr_in = rs + 5'd1;
      bus.op1                = a;
      bus.op2                = b;
      bus.source             = src;
      bus.store              = st;
      bus.size               = sz;
      bus.sign_ext           = sx;
      bus.byte_rev           = rv;
   endtask

   // One aligned op end to end at minimum latency, with the memory answering at once.
   task automatic run_op(input string tag, input logic [4:0] rs, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] src, input logic st,
                         input logic [1:0] sz, input logic sx, input logic rv,
                         input logic [31:0] rdata, input logic [31:0] exp_addr,
                         input logic [3:0] exp_ren, input logic [3:0] exp_wen,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_res);
      @(negedge clk);
      drive_op(rs, a, b, src, st, sz, sx, rv);
      bus.input_valid = 1'b1;
      #1 chk({tag, ".in_rdy"}, bus.input_ready, 1);
      @(posedge clk);
      #1 bus.input_valid = 1'b0;
      @(negedge clk);
      #1 chk({tag, ".req_early"}, bus.to_mem_valid, 0);
      @(negedge clk);
      #1;
      chk({tag, ".req_vld"}, bus.to_mem_valid, 1);
      chk({tag, ".addr"}, bus.mem_address, exp_addr);
      chk({tag, ".ren"}, bus.mem_read_en, exp_ren);
      chk({tag, ".wen"}, bus.mem_write_en, exp_wen);
      chk({tag, ".wdata"}, bus.mem_write_data, exp_wdata);
      bus.to_mem_ready = 1'b1;
      @(posedge clk);
      #1 bus.to_mem_ready = 1'b0;
      @(negedge clk);
      bus.from_mem_valid = 1'b1;
      bus.mem_read_data  = rdata;
      #1 chk({tag, ".rsp_rdy"}, bus.from_mem_ready, 1);
      @(posedge clk);
      #1 bus.from_mem_valid = 1'b0;
      @(negedge clk);
      #1;
      chk({tag, ".out_vld"}, bus.output_valid, 1);
      chk({tag, ".result"}, bus.result, exp_res);
      chk({tag, ".rs_id"}, bus.rs_id_out, rs);
      chk({tag, ".rd"}, bus.result_reg_addr_out, rs + 5'd1);
      chk({tag, ".aerr"}, bus.align_error, 0);
   endtask

   initial begin
      logic        seen_req;
      logic        got_out;
      logic [31:0] mis_res;
      logic        mis_err;
      logic [4:0]  mis_rs;
      int          issued;
      int          accepts;
      logic        rdy_s;
      logic        req_s;

      bus.input_valid    = 1'b0;
      bus.output_ready   = 1'b1;
      bus.to_mem_ready   = 1'b0;
      bus.from_mem_valid = 1'b0;
      bus.mem_read_data  = '0;
      drive_op(5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst.out_vld", bus.output_valid, 0);
      chk("rst.req_vld", bus.to_mem_valid, 0);
      chk("rst.in_rdy", bus.input_ready, 1);
      chk("rst.rsp_rdy", bus.from_mem_ready, 0);
      chk("rst.result", bus.result, 0);
      chk("rst.aerr", bus.align_error, 0);
      chk("rst.wen", bus.mem_write_en, 0);

      run_op("lbs", 5'd3, 32'h0000_1000, 32'h3, 32'h0, 1'b0, 2'd0, 1'b1, 1'b0,
             32'h0000_00F0, 32'h0000_1000, 4'b0001, 4'b0000, 32'h0, 32'hFFFF_FFF0);
      run_op("sth", 5'd4, 32'h0000_2000, 32'h1, 32'h0000_ABCD, 1'b1, 2'd1, 1'b0, 1'b0,
             32'hDEAD_BEEF, 32'h0000_2000, 4'b0000, 4'b0110, 32'h00AB_CD00, 32'h0);
      run_op("lhs", 5'd5, 32'h0000_5000, 32'h2, 32'h0, 1'b0, 2'd1, 1'b1, 1'b0,
             32'h1234_8001, 32'h0000_5000, 4'b0011, 4'b0000, 32'h0, 32'hFFFF_8001);
`ifdef LSU_BYTE_REVERSE_EN
      run_op("lwbr", 5'd6, 32'h0000_4000, 32'h0, 32'h0, 1'b0, 2'd3, 1'b0, 1'b1,
             32'h1122_3344, 32'h0000_4000, 4'b1111, 4'b0000, 32'h0, 32'h4433_2211);
`else
      run_op("lwbr", 5'd6, 32'h0000_4000, 32'h0, 32'h0, 1'b0, 2'd3, 1'b0, 1'b1,
             32'h1122_3344, 32'h0000_4000, 4'b1111, 4'b0000, 32'h0, 32'h1122_3344);
`endif

      // Misaligned word load: no memory traffic, error completion.
      @(negedge clk);
      drive_op(5'd9, 32'h0000_2000, 32'h2, 32'h0, 1'b0, 2'd3, 1'b0, 1'b0);
      bus.input_valid = 1'b1;
      @(posedge clk);
      #1 bus.input_valid = 1'b0;
      seen_req = 1'b0;
      got_out  = 1'b0;
      mis_res  = '1;
      mis_err  = 1'b0;
      mis_rs   = '0;
      for (int i = 0; i < 10 && !got_out; i++) begin
         @(negedge clk);
         #1;
         if (bus.to_mem_valid) seen_req = 1'b1;
         if (bus.output_valid) begin
            got_out = 1'b1;
            mis_res = bus.result;
            mis_err = bus.align_error;
            mis_rs  = bus.rs_id_out;
         end
      end
      chk("mis.no_req", seen_req, 0);
      chk("mis.out_vld", got_out, 1);
      chk("mis.aerr", mis_err, 1);
      chk("mis.result", mis_res, 0);
      chk("mis.rs_id", mis_rs, 5'd9);

      // Memory accepts but never answers: only two requests may be outstanding.
      bus.to_mem_ready = 1'b1;
      issued  = 0;
      accepts = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         bus.input_valid = (issued < 5);
         drive_op(5'(10 + issued), 32'h0000_3000, 32'(issued), 32'h0, 1'b0, 2'd0, 1'b0, 1'b0);
         #1;
         rdy_s = bus.input_ready;
         req_s = bus.to_mem_valid;
         @(posedge clk);
         if (bus.input_valid && rdy_s) issued++;
         if (req_s) accepts++;
         #1;
      end
      bus.input_valid  = 1'b0;
      bus.to_mem_ready = 1'b0;
      chk("cap.accepts", 32'(accepts), 2);
      chk("cap.issued", 32'(issued), 4);
      @(negedge clk);
      #1;
      chk("cap.req_vld", bus.to_mem_valid, 0);
      chk("cap.in_rdy", bus.input_ready, 0);

      // Output stalled while both responses are pending.
      bus.output_ready   = 1'b0;
      bus.from_mem_valid = 1'b1;
      bus.mem_read_data  = 32'h8A00_0000;
      #1 chk("stall.rsp0_rdy", bus.from_mem_ready, 1);
      @(posedge clk);
      #1 bus.mem_read_data = 32'h005B_0000;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         #1;
         chk("stall.rsp_rdy", bus.from_mem_ready, 0);
         chk("stall.hold_rs", bus.rs_id_out, 5'd10);
      end
      chk("stall.res0", bus.result, 32'h0000_008A);
      @(negedge clk);
      bus.output_ready = 1'b1;
      #1 chk("stall.rsp1_rdy", bus.from_mem_ready, 1);
      @(posedge clk);
      #1 bus.from_mem_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("stall.out1_vld", bus.output_valid, 1);
      chk("stall.rs1", bus.rs_id_out, 5'd11);
      chk("stall.res1", bus.result, 32'h0000_005B);
      chk("stall.reopen", bus.to_mem_valid, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
